acesso_memoria: RTL and testbench
=================================

ACESSO_MEMORIA -- requirements
Module: acesso_memoria

Interface
REQ-001 LATENCIA_LEITURA, 2, memory read latency in cycles from address presentation to valid MemDataIn; legal range 1..7.
REQ-002 Clock  in  1  sole clock, all state on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low; 0 forces reset state immediately.
REQ-004 Req  in  1  access request from controlador; sampled only in OCIOSO.
REQ-005 Esc  in  1  1=write, 0=read; sampled with Req.
REQ-006 IouD  in  1  0=instruction fetch at PC, 1=data access at ULASaida; sampled with Req.
REQ-007 PC  in  32  fetch address.
REQ-008 ULASaida  in  32  data address.
REQ-009 DadoB  in  32  store data.
REQ-010 MemDataIn  in  32  read data from memory.
REQ-011 MemAddr  out  32  registered address to memory.
REQ-012 MemWr  out  1  memory write strobe.
REQ-013 MemDataOut  out  32  registered store data.
REQ-014 Instr  out  32  instruction register; OpCode=Instr[31:26], InstrArit=Instr[5:0] also output (6 bits each).
REQ-015 MDR  out  32  memory data register.
REQ-016 Ocupado  out  1  high in every state except OCIOSO.
REQ-017 Pronto  out  1  one-cycle completion pulse.
REQ-018 Erro  out  1  one-cycle misalignment pulse, coincident with Pronto.

Function
REQ-019 FSM states: OCIOSO, ESPERA, CAPTURA, ESCRITA.
REQ-020 OCIOSO with Req=1: latch MemAddr=(IouD?ULASaida:PC), MemDataOut=DadoB, Esc, IouD; Esc=1 -> ESCRITA, Esc=0 -> ESPERA with counter=LATENCIA_LEITURA-1.
REQ-021 OCIOSO with Req=0: remain, MemAddr/MemDataOut hold.
REQ-022 ESPERA: counter decrements each cycle; at counter==0 -> CAPTURA; MemAddr stable throughout.
REQ-023 CAPTURA: Pronto=1; on exit edge load MemDataIn into Instr (IouD=0) or MDR (IouD=1), never both; -> OCIOSO.
REQ-024 Read latency: Req sampled at edge 0, Pronto high in cycle LATENCIA_LEITURA+1, register valid from cycle LATENCIA_LEITURA+2.
REQ-025 ESCRITA: MemWr=1 and Pronto=1 for exactly one cycle; Instr/MDR unchanged; -> OCIOSO.
REQ-026 Req while Ocupado=1 ignored; not queued.
REQ-027 Back-to-back: Req held high re-issues on first OCIOSO cycle after Pronto (one idle cycle minimum).
REQ-028 Instr and MDR change only in CAPTURA.
REQ-029 Counter 3 bits, never wraps; LATENCIA_LEITURA=1 passes ESPERA exactly one cycle.

Reset
REQ-030 Reset=0: state OCIOSO, counter 0, MemAddr, MemDataOut, Instr, MDR = 0; MemWr, Pronto, Erro, Ocupado = 0, asynchronously.
REQ-031 Reset mid-access aborts it: no Pronto, no register load, MemWr drops without waiting for a clock.
REQ-032 First Req honoured on first rising edge after Reset returns to 1.

Configuration
REQ-033 Macro ACESSO_ALINHAMENTO_EN defined: Req with IouD=1 and selected address[1:0]!=0 performs no memory access, goes directly to CAPTURA with Pronto=1, Erro=1, no register load.
REQ-034 Macro undefined: no alignment check; Erro tied 0; address forwarded unchanged.

Structure
REQ-035 Shared package holds state enum (4 states, 2 bits), word width 32, opcode/funct field positions, default latency constant.
REQ-036 One sub-module registrador_en (32-bit, enable, async active-low clear) instantiated for Instr, MDR, MemAddr, MemDataOut.

Verification
REQ-037 Fetch: PC=0x00000004, Req=1, IouD=0, Esc=0, MemDataIn=0x8C220008 -> Pronto in cycle 3, Instr=0x8C220008, OpCode=6'b100011, MDR unchanged.
REQ-038 Load: ULASaida=0x00000010, IouD=1, MemDataIn=0x0000ABCD -> MemAddr=0x10, MDR=0x0000ABCD, Instr unchanged.
REQ-039 Store: ULASaida=0x20, DadoB=0xDEADBEEF, Esc=1 -> one-cycle MemWr with MemAddr=0x20, MemDataOut=0xDEADBEEF, Pronto same cycle.
REQ-040 Req pulsed in ESPERA -> ignored; exactly one Pronto observed.
REQ-041 Reset=0 in ESPERA -> all outputs 0 immediately, no Pronto; next Req completes normally.
REQ-042 With ACESSO_ALINHAMENTO_EN, IouD=1, ULASaida=0x13 -> Pronto=Erro=1 one cycle after Req, MemWr=0, MDR unchanged.

Source files
------------

// File: rtl/acesso_memoria_pkg.sv
// ---------------------------------------------------------------------------
// acesso_memoria_pkg
// Shared definitions for the memory access unit of the multicycle processor:
// FSM state encoding, word width, instruction field positions and the
// default read latency. Also holds the word-alignment helper.
// ---------------------------------------------------------------------------
package acesso_memoria_pkg;

  // Memory access FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESPERA  = 2'd1,
    CAPTURA = 2'd2,
    ESCRITA = 2'd3
  } estado_t;

  // Data path word width.
  localparam int PALAVRA = 32;

  // Instruction field positions.
  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 26;
  localparam int FUNCT_MSB  = 5;
  localparam int FUNCT_LSB  = 0;

  // Default memory read latency in cycles (legal range 1..7).
  localparam int LATENCIA_PADRAO = 2;

  // A word access is misaligned when either of the two low address bits is set.
  function automatic logic endereco_desalinhado(input logic [1:0] lsb);
    return (lsb != 2'b00);
  endfunction

endpackage

// File: rtl/acesso_memoria_registrador_en.sv
// ---------------------------------------------------------------------------
// registrador_en
// 32-bit register with load enable and asynchronous active-low clear.
// Ports:
//   Clock - rising-edge clock
//   Reset - asynchronous active-low clear (Q forced to 0)
//   En    - load enable; Q holds when low
//   D     - data in
//   Q     - registered data out
// ---------------------------------------------------------------------------
module registrador_en
  import acesso_memoria_pkg::*;
(
  input  logic               Clock,
  input  logic               Reset,
  input  logic               En,
  input  logic [PALAVRA-1:0] D,
  output logic [PALAVRA-1:0] Q
);

  // Storage element: clear on reset, load on enable, otherwise hold.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      Q <= {PALAVRA{1'b0}};
    end else if (En) begin
      Q <= D;
    end else begin
      Q <= Q;
    end
  end

endmodule

// File: rtl/acesso_memoria.sv
// ---------------------------------------------------------------------------
// acesso_memoria
// Memory access unit: accepts a request from the controller, drives the
// registered address/store data to memory, waits the read latency and
// captures the returned word into the instruction register (fetch) or the
// memory data register (data load). Writes take a single strobe cycle.
//
// Optional feature: define ACESSO_ALINHAMENTO_EN to reject misaligned data
// accesses (IouD=1, address[1:0]!=0). Such a request skips memory entirely
// and completes the next cycle with Pronto=Erro=1 and no register load.
// With the macro undefined there is no check and Erro is always 0.
//
// Ports:
//   Clock, Reset       - clock (rising edge), async active-low reset
//   Req, Esc, IouD     - request, write(1)/read(0), data(1)/fetch(0)
//   PC, ULASaida       - fetch address, data address
//   DadoB              - store data
//   MemDataIn          - read data returned by memory
//   MemAddr, MemWr     - registered address and write strobe to memory
//   MemDataOut         - registered store data
//   Instr, OpCode,
//   InstrArit          - instruction register and its opcode/funct fields
//   MDR                - memory data register
//   Ocupado            - high whenever not idle
//   Pronto, Erro       - one-cycle completion / misalignment pulses
// ---------------------------------------------------------------------------
module acesso_memoria
  import acesso_memoria_pkg::*;
#(
  parameter int LATENCIA_LEITURA = LATENCIA_PADRAO
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Req,
  input  logic        Esc,
  input  logic        IouD,
  input  logic [31:0] PC,
  input  logic [31:0] ULASaida,
  input  logic [31:0] DadoB,
  input  logic [31:0] MemDataIn,
  output logic [31:0] MemAddr,
  output logic        MemWr,
  output logic [31:0] MemDataOut,
  output logic [31:0] Instr,
  output logic [5:0]  OpCode,
  output logic [5:0]  InstrArit,
  output logic [31:0] MDR,
  output logic        Ocupado,
  output logic        Pronto,
  output logic        Erro
);

  // ESPERA runs for counter values LATENCIA-1 down to 0, one cycle each.
  localparam logic [2:0] CARGA_CONTADOR = 3'(LATENCIA_LEITURA - 1);

  estado_t      estado_r;
  estado_t      estado_s;
  logic [2:0]   contador_r;
  logic [2:0]   contador_s;
  logic         esc_r;
  logic         ioud_r;
  logic         erro_flag_r;
  logic         erro_flag_s;
  logic         aceita_s;
  logic         desalinhado_s;
  logic [31:0]  endereco_sel_s;
  logic         carga_instr_s;
  logic         carga_mdr_s;
  logic         pronto_r;
  logic         memwr_r;
  logic         ocupado_r;
  logic         erro_r;

  assign endereco_sel_s = IouD ? ULASaida : PC;
  // Requests are only looked at while idle; anything arriving while busy is dropped.
  assign aceita_s       = (estado_r == OCIOSO) && Req;

`ifdef ACESSO_ALINHAMENTO_EN
  assign desalinhado_s = IouD && endereco_desalinhado(endereco_sel_s[1:0]);
`else
  assign desalinhado_s = 1'b0;
`endif

  // The error flag is captured with the request and kept for the CAPTURA cycle.
  assign erro_flag_s = aceita_s ? desalinhado_s : erro_flag_r;

  // Next-state and counter logic.
  always_comb begin
    estado_s   = estado_r;
    contador_s = contador_r;
    case (estado_r)
      OCIOSO: begin
        if (Req) begin
          if (desalinhado_s) begin
            estado_s   = CAPTURA;
            contador_s = 3'd0;
          end else if (Esc) begin
            estado_s   = ESCRITA;
            contador_s = 3'd0;
          end else begin
            estado_s   = ESPERA;
            contador_s = CARGA_CONTADOR;
          end
        end else begin
          estado_s   = OCIOSO;
          contador_s = contador_r;
        end
      end
      ESPERA: begin
        if (contador_r == 3'd0) begin
          estado_s   = CAPTURA;
          contador_s = 3'd0;
        end else begin
          estado_s   = ESPERA;
          contador_s = contador_r - 3'd1;
        end
      end
      CAPTURA: begin
        estado_s   = OCIOSO;
        contador_s = 3'd0;
      end
      ESCRITA: begin
        estado_s   = OCIOSO;
        contador_s = 3'd0;
      end
      default: begin
        estado_s   = OCIOSO;
        contador_s = 3'd0;
      end
    endcase
  end

  // State, counter, request attributes and registered status outputs.
  // Outputs are derived from the next state so they are aligned with it.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      estado_r    <= OCIOSO;
      contador_r  <= 3'd0;
      esc_r       <= 1'b0;
      ioud_r      <= 1'b0;
      erro_flag_r <= 1'b0;
      pronto_r    <= 1'b0;
      memwr_r     <= 1'b0;
      ocupado_r   <= 1'b0;
      erro_r      <= 1'b0;
    end else begin
      estado_r    <= estado_s;
      contador_r  <= contador_s;
      esc_r       <= aceita_s ? Esc  : esc_r;
      ioud_r      <= aceita_s ? IouD : ioud_r;
      erro_flag_r <= erro_flag_s;
      pronto_r    <= (estado_s == CAPTURA) || (estado_s == ESCRITA);
      memwr_r     <= (estado_s == ESCRITA);
      ocupado_r   <= (estado_s != OCIOSO);
      erro_r      <= (estado_s == CAPTURA) && erro_flag_s;
    end
  end

  // Only a completed, error-free read loads exactly one destination register.
  assign carga_instr_s = (estado_r == CAPTURA) && !esc_r && !erro_flag_r && !ioud_r;
  assign carga_mdr_s   = (estado_r == CAPTURA) && !esc_r && !erro_flag_r &&  ioud_r;

  registrador_en u_mem_addr (
    .Clock (Clock),
    .Reset (Reset),
    .En    (aceita_s),
    .D     (endereco_sel_s),
    .Q     (MemAddr)
  );

  registrador_en u_mem_data_out (
    .Clock (Clock),
    .Reset (Reset),
    .En    (aceita_s),
    .D     (DadoB),
    .Q     (MemDataOut)
  );

  registrador_en u_instr (
    .Clock (Clock),
    .Reset (Reset),
    .En    (carga_instr_s),
    .D     (MemDataIn),
    .Q     (Instr)
  );

  registrador_en u_mdr (
    .Clock (Clock),
    .Reset (Reset),
    .En    (carga_mdr_s),
    .D     (MemDataIn),
    .Q     (MDR)
  );

  assign OpCode    = Instr[OPCODE_MSB:OPCODE_LSB];
  assign InstrArit = Instr[FUNCT_MSB:FUNCT_LSB];
  assign Pronto    = pronto_r;
  assign MemWr     = memwr_r;
  assign Ocupado   = ocupado_r;
  assign Erro      = erro_r;

endmodule

// File: tb/tb_acesso_memoria.sv
// ---------------------------------------------------------------------------
// tb_acesso_memoria
// Directed bench for acesso_memoria (LATENCIA_LEITURA = 2). Inputs are
// driven 1 time unit after the rising edge; outputs are sampled there too,
// so a value checked after N ticks is the value during cycle N.
// ---------------------------------------------------------------------------
module tb_acesso_memoria;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        Req = 1'b0;
  logic        Esc = 1'b0;
  logic        IouD = 1'b0;
  logic [31:0] PC = 32'h0;
  logic [31:0] ULASaida = 32'h0;
  logic [31:0] DadoB = 32'h0;
  logic [31:0] MemDataIn = 32'h0;
  logic [31:0] MemAddr;
  logic        MemWr;
  logic [31:0] MemDataOut;
  logic [31:0] Instr;
  logic [5:0]  OpCode;
  logic [5:0]  InstrArit;
  logic [31:0] MDR;
  logic        Ocupado;
  logic        Pronto;
  logic        Erro;

  int checks = 0;
  int errors = 0;

  acesso_memoria #(.LATENCIA_LEITURA(2)) dut (
    .Clock      (Clock),
    .Reset      (Reset),
    .Req        (Req),
    .Esc        (Esc),
    .IouD       (IouD),
    .PC         (PC),
    .ULASaida   (ULASaida),
    .DadoB      (DadoB),
    .MemDataIn  (MemDataIn),
    .MemAddr    (MemAddr),
    .MemWr      (MemWr),
    .MemDataOut (MemDataOut),
    .Instr      (Instr),
    .OpCode     (OpCode),
    .InstrArit  (InstrArit),
    .MDR        (MDR),
    .Ocupado    (Ocupado),
    .Pronto     (Pronto),
    .Erro       (Erro)
  );

  always #5 Clock = ~Clock;

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  task automatic test_reset;
    #1 Reset = 1'b0;
    #2;
    checks++; if (MemAddr !== 32'h0) begin errors++; $display("FAIL reset_memaddr: got %h expected %h", MemAddr, 32'h0); end
    checks++; if (MemDataOut !== 32'h0) begin errors++; $display("FAIL reset_memdataout: got %h expected %h", MemDataOut, 32'h0); end
    checks++; if (Instr !== 32'h0 || MDR !== 32'h0) begin errors++; $display("FAIL reset_regs: got instr %h mdr %h expected 0", Instr, MDR); end
    checks++; if ({MemWr, Pronto, Erro, Ocupado} !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected %b", {MemWr, Pronto, Erro, Ocupado}, 4'b0000); end
    tick; tick;
    @(negedge Clock);
    Reset = 1'b1;
    tick;
  endtask

  task automatic test_fetch;
    PC = 32'h0000_0004; IouD = 1'b0; Esc = 1'b0; MemDataIn = 32'h8C22_0008; Req = 1'b1;
    tick; Req = 1'b0;
    checks++; if (Ocupado !== 1'b1 || Pronto !== 1'b0) begin errors++; $display("FAIL fetch_c1: got ocupado %b pronto %b expected 1 0", Ocupado, Pronto); end
    checks++; if (MemAddr !== 32'h4) begin errors++; $display("FAIL fetch_addr: got %h expected %h", MemAddr, 32'h4); end
    tick;
    checks++; if (Pronto !== 1'b0) begin errors++; $display("FAIL fetch_c2_pronto: got %b expected 0", Pronto); end
    tick;
    checks++; if (Pronto !== 1'b1 || MemWr !== 1'b0) begin errors++; $display("FAIL fetch_c3: got pronto %b memwr %b expected 1 0", Pronto, MemWr); end
    checks++; if (Instr !== 32'h0) begin errors++; $display("FAIL fetch_c3_instr_early: got %h expected %h", Instr, 32'h0); end
    tick;
    checks++; if (Pronto !== 1'b0 || Ocupado !== 1'b0) begin errors++; $display("FAIL fetch_c4_flags: got pronto %b ocupado %b expected 0 0", Pronto, Ocupado); end
    checks++; if (Instr !== 32'h8C22_0008) begin errors++; $display("FAIL fetch_instr: got %h expected %h", Instr, 32'h8C22_0008); end
    checks++; if (OpCode !== 6'b100011 || InstrArit !== 6'b001000) begin errors++; $display("FAIL fetch_fields: got %b %b expected 100011 001000", OpCode, InstrArit); end
    checks++; if (MDR !== 32'h0) begin errors++; $display("FAIL fetch_mdr_unchanged: got %h expected %h", MDR, 32'h0); end
  endtask

  task automatic test_load;
    ULASaida = 32'h0000_0010; IouD = 1'b1; Esc = 1'b0; MemDataIn = 32'h0000_ABCD; Req = 1'b1;
    tick; Req = 1'b0;
    checks++; if (MemAddr !== 32'h10) begin errors++; $display("FAIL load_addr: got %h expected %h", MemAddr, 32'h10); end
    tick; tick;
    checks++; if (Pronto !== 1'b1) begin errors++; $display("FAIL load_pronto: got %b expected 1", Pronto); end
    tick;
    checks++; if (MDR !== 32'h0000_ABCD) begin errors++; $display("FAIL load_mdr: got %h expected %h", MDR, 32'h0000_ABCD); end
    checks++; if (Instr !== 32'h8C22_0008) begin errors++; $display("FAIL load_instr_unchanged: got %h expected %h", Instr, 32'h8C22_0008); end
  endtask

  task automatic test_store;
    ULASaida = 32'h0000_0020; DadoB = 32'hDEAD_BEEF; IouD = 1'b1; Esc = 1'b1; MemDataIn = 32'h5555_5555; Req = 1'b1;
    tick; Req = 1'b0;
    checks++; if (MemWr !== 1'b1 || Pronto !== 1'b1) begin errors++; $display("FAIL store_c1: got memwr %b pronto %b expected 1 1", MemWr, Pronto); end
    checks++; if (MemAddr !== 32'h20 || MemDataOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_bus: got %h %h expected %h %h", MemAddr, MemDataOut, 32'h20, 32'hDEAD_BEEF); end
    tick;
    checks++; if ({MemWr, Pronto, Ocupado} !== 3'b000) begin errors++; $display("FAIL store_c2: got %b expected %b", {MemWr, Pronto, Ocupado}, 3'b000); end
    checks++; if (MDR !== 32'h0000_ABCD || Instr !== 32'h8C22_0008) begin errors++; $display("FAIL store_regs_unchanged: got %h %h expected %h %h", MDR, Instr, 32'h0000_ABCD, 32'h8C22_0008); end
    Esc = 1'b0;
  endtask

  task automatic test_ignored_req;
    int prontos;
    PC = 32'h0000_0008; IouD = 1'b0; Esc = 1'b0; MemDataIn = 32'h1111_1111; Req = 1'b1;
    tick;
    prontos = (Pronto === 1'b1) ? 1 : 0;
    PC = 32'h0000_000C;
    tick; Req = 1'b0;
    prontos += (Pronto === 1'b1) ? 1 : 0;
    checks++; if (MemAddr !== 32'h8) begin errors++; $display("FAIL ignored_addr_stable: got %h expected %h", MemAddr, 32'h8); end
    for (int i = 0; i < 6; i++) begin
      tick;
      prontos += (Pronto === 1'b1) ? 1 : 0;
    end
    checks++; if (prontos !== 1) begin errors++; $display("FAIL ignored_pronto_count: got %0d expected %0d", prontos, 1); end
    checks++; if (Instr !== 32'h1111_1111) begin errors++; $display("FAIL ignored_instr: got %h expected %h", Instr, 32'h1111_1111); end
  endtask

  task automatic test_back_to_back;
    ULASaida = 32'h0000_0024; DadoB = 32'hDEAD_BEEF; IouD = 1'b1; Esc = 1'b1; Req = 1'b1;
    tick;
    checks++; if (Pronto !== 1'b1 || MemDataOut !== 32'hDEAD_BEEF) begin errors++; $display("FAIL b2b_first: got pronto %b data %h expected 1 %h", Pronto, MemDataOut, 32'hDEAD_BEEF); end
    DadoB = 32'h1234_5678;
    tick;
    checks++; if (Pronto !== 1'b0 || Ocupado !== 1'b0) begin errors++; $display("FAIL b2b_idle: got pronto %b ocupado %b expected 0 0", Pronto, Ocupado); end
    tick; Req = 1'b0;
    checks++; if (Pronto !== 1'b1 || MemWr !== 1'b1 || MemDataOut !== 32'h1234_5678) begin errors++; $display("FAIL b2b_second: got pronto %b memwr %b data %h expected 1 1 %h", Pronto, MemWr, MemDataOut, 32'h1234_5678); end
    tick;
    Esc = 1'b0;
  endtask

  task automatic test_reset_mid;
    int prontos;
    ULASaida = 32'h0000_0030; IouD = 1'b1; Esc = 1'b0; DadoB = 32'hCAFE_F00D; MemDataIn = 32'h0000_0055; Req = 1'b1;
    tick; Req = 1'b0;
    #2 Reset = 1'b0;
    #1;
    checks++; if ({MemWr, Pronto, Erro, Ocupado} !== 4'b0000) begin errors++; $display("FAIL midreset_flags: got %b expected %b", {MemWr, Pronto, Erro, Ocupado}, 4'b0000); end
    checks++; if (MemAddr !== 32'h0 || MemDataOut !== 32'h0 || Instr !== 32'h0 || MDR !== 32'h0) begin errors++; $display("FAIL midreset_regs: got %h %h %h %h expected 0", MemAddr, MemDataOut, Instr, MDR); end
    prontos = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      prontos += (Pronto === 1'b1) ? 1 : 0;
    end
    @(negedge Clock);
    Reset = 1'b1;
    ULASaida = 32'h0000_0040; MemDataIn = 32'h0000_0077; Req = 1'b1;
    tick; Req = 1'b0;
    prontos += (Pronto === 1'b1) ? 1 : 0;
    checks++; if (prontos !== 0 || Ocupado !== 1'b1 || MemAddr !== 32'h40) begin errors++; $display("FAIL midreset_restart: got prontos %0d ocupado %b addr %h expected 0 1 %h", prontos, Ocupado, MemAddr, 32'h40); end
    tick; tick;
    checks++; if (Pronto !== 1'b1) begin errors++; $display("FAIL midreset_pronto: got %b expected 1", Pronto); end
    tick;
    checks++; if (MDR !== 32'h0000_0077 || Instr !== 32'h0) begin errors++; $display("FAIL midreset_mdr: got mdr %h instr %h expected %h 0", MDR, Instr, 32'h0000_0077); end
  endtask

  task automatic test_alinhamento;
    ULASaida = 32'h0000_0013; IouD = 1'b1; Esc = 1'b0; MemDataIn = 32'h0000_0099; Req = 1'b1;
    tick; Req = 1'b0;
`ifdef ACESSO_ALINHAMENTO_EN
    checks++; if ({Pronto, Erro, MemWr} !== 3'b110) begin errors++; $display("FAIL align_pulse: got %b expected %b", {Pronto, Erro, MemWr}, 3'b110); end
    tick;
    checks++; if ({Pronto, Erro, Ocupado} !== 3'b000) begin errors++; $display("FAIL align_after: got %b expected %b", {Pronto, Erro, Ocupado}, 3'b000); end
    checks++; if (MDR !== 32'h0000_0077) begin errors++; $display("FAIL align_mdr_unchanged: got %h expected %h", MDR, 32'h0000_0077); end
`else
    checks++; if (Erro !== 1'b0 || MemAddr !== 32'h13 || Pronto !== 1'b0) begin errors++; $display("FAIL noalign_c1: got erro %b addr %h pronto %b expected 0 %h 0", Erro, MemAddr, Pronto, 32'h13); end
    tick; tick;
    checks++; if (Pronto !== 1'b1 || Erro !== 1'b0) begin errors++; $display("FAIL noalign_c3: got pronto %b erro %b expected 1 0", Pronto, Erro); end
    tick;
    checks++; if (MDR !== 32'h0000_0099) begin errors++; $display("FAIL noalign_mdr: got %h expected %h", MDR, 32'h0000_0099); end
`endif
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_load;
    test_store;
    test_ignored_req;
    test_back_to_back;
    test_reset_mid;
    test_alinhamento;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
